// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, taken-branch and
// memory-wait hazards into per-stage stall/flush controls, with a
// bounded memory wait (sticky timeout) and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rdE,
  input  logic             loadE,
  input  logic             branchTakenE,
  input  logic             memReqM,
  input  logic             memDoneM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             timeout,
  output logic [31:0]      stallCount
);

  localparam int unsigned          CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]     WAIT_LIM = CNT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             pend, pend_nxt;
  logic             timeout_nxt;
  logic             mem_wait, load_use;

  assign mem_wait = memReqM & ~memDoneM;
  assign load_use = loadE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

  // State, wait counter, redirect-pending and sticky timeout registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      pend     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      pend     <= pend_nxt;
      timeout  <= timeout_nxt;
    end
  end

  // Next-state and combinational stall/flush decode; all controls forced low in reset
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pend_nxt     = pend;
    timeout_nxt  = timeout;
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushW = 1'b0;
    case (state)
      RUN, REDIRECT: begin
        if (mem_wait) begin
          stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
          flushW       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
          // remember the I-memory bubble still owed when the wait ends
          pend_nxt     = (state == REDIRECT);
        end else if (branchTakenE) begin
          flushD    = 1'b1;
          flushE    = 1'b1;
          state_nxt = REDIRECT;
        end else if (state == REDIRECT) begin
          flushD    = 1'b1;
          state_nxt = RUN;
        end else if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
        flushW = 1'b1;
        if (memDoneM || (wait_cnt == WAIT_LIM)) begin
          if (!memDoneM) timeout_nxt = 1'b1;
          state_nxt = pend ? REDIRECT : RUN;
          pend_nxt  = 1'b0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (reset) begin
      stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
      flushD = 1'b0; flushE = 1'b0; flushW = 1'b0;
    end
  end

  // Saturating count of cycles with fetch stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stallCount <= '0;
    else if (stallF && (stallCount != '1))
      stallCount <= stallCount + 32'd1;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter WAIT_MAX, default 255, meaning maximum memory-wait cycles before timeout (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rs1D, rs2D  input  REG_W  source registers of the instruction in Decode.
REQ-006 SHALL have ports rdE  input  REG_W  and loadE  input  1  destination and load flag of the instruction in Execute.
REQ-007 SHALL have port branchTakenE  input  1  taken branch/jump resolved in Execute.
REQ-008 SHALL have ports memReqM, memDoneM  input  1  memory access active in Memory stage; data ready.
REQ-009 SHALL have ports stallF, stallD, stallE, stallM  output  1  hold the matching pipeline register.
REQ-010 SHALL have ports flushD, flushE, flushW  output  1  zero the matching pipeline register.
REQ-011 SHALL have port timeout  output  1  sticky memory-wait timeout flag.
REQ-012 SHALL have port stallCount  output  32  saturating count of cycles with stallF=1.

Function
REQ-013 SHALL implement a three-state FSM: RUN, MEM_WAIT, REDIRECT.
REQ-014 SHALL define memWait = memReqM & ~memDoneM; loadUse = loadE & (rdE!=0) & (rdE==rs1D | rdE==rs2D).
REQ-015 SHALL give priority memWait > branchTakenE > loadUse in RUN and REDIRECT.
REQ-016 RUN, memWait: SHALL assert stallF/D/E/M and flushW, no other flush; next MEM_WAIT; wait counter cleared to 0.
REQ-017 RUN, branchTakenE (no memWait): SHALL assert flushD, flushE, no stalls; next REDIRECT.
REQ-018 RUN, loadUse only: SHALL assert stallF, stallD, flushE for that cycle; stay RUN.
REQ-019 RUN, memReqM & memDoneM in same cycle: SHALL cause no stall.
REQ-020 REDIRECT: SHALL assert flushD (synchronous I-memory bubble), no stalls; next RUN.
REQ-021 REDIRECT with memWait: SHALL behave as REQ-016, additionally set redirect-pending bit.
REQ-022 MEM_WAIT: SHALL assert stallF/D/E/M and flushW every cycle; branchTakenE and loadUse ignored.
REQ-023 MEM_WAIT: wait counter SHALL increment by 1 per cycle, width clog2(WAIT_MAX+1).
REQ-024 MEM_WAIT, memDoneM: SHALL still output the REQ-022 values that cycle; next REDIRECT if redirect-pending else RUN; pending cleared.
REQ-025 MEM_WAIT, counter==WAIT_MAX without memDoneM: SHALL set timeout and leave as in REQ-024.
REQ-026 timeout SHALL remain 1 until reset.
REQ-027 stallCount SHALL increment each cycle stallF=1, saturating at 0xFFFF_FFFF.
REQ-028 All stall/flush outputs SHALL be combinational from state and inputs; no added latency.

Reset
REQ-029 reset=1 SHALL immediately force state RUN, wait counter 0, redirect-pending 0, timeout 0, stallCount 0.
REQ-030 While reset=1 all stall and flush outputs SHALL be 0.
REQ-031 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no timeout; first cycle after release evaluates as RUN.

Verification
REQ-032 loadE=1, rdE=5, rs1D=5, one cycle -> stallF=stallD=flushE=1 that cycle, state RUN, stallCount=1.
REQ-033 loadE=1, rdE=0, rs2D=0 -> no stall or flush.
REQ-034 branchTakenE=1 with loadUse true -> flushD=flushE=1, stalls 0; next cycle flushD=1 only; then RUN.
REQ-035 memReqM=1, memDoneM=0 for 3 cycles then 1 -> stalls and flushW high 4 cycles, RUN after, stallCount=4.
REQ-036 WAIT_MAX=4, memReqM=1, memDoneM never -> timeout=1 after counter reaches 4, FSM RUN, timeout sticky until reset.
REQ-037 branch taken, memWait in REDIRECT for 2 cycles, memDoneM -> MEM_WAIT then one REDIRECT cycle with flushD=1, then RUN.
